// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and shift-mode constants
// used by the shift units and the ALU sequencer.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shr_state_e;

    localparam logic SHR_LOGICAL = 1'b0;
    localparam logic SHR_ARITH   = 1'b1;

endpackage : alu_pkg

// File: rtl/alu_shr_step.sv
// One-position right shift with selectable fill: sign copy in arithmetic
// mode, zero otherwise. Kept separate so a barrel version can chain it.
module alu_shr_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] din,
    input  logic             mode,
    output logic [WIDTH-1:0] dout
);

    logic fill_s;

    assign fill_s = (mode == SHR_ARITH) ? din[WIDTH-1] : 1'b0;
    assign dout   = {fill_s, din[WIDTH-1:1]};

endmodule : alu_shr_step

// File: rtl/alu_shr_seq.sv
// Multi-cycle SHR/SAR unit: shifts one bit per clock under a start/busy/done
// handshake; the result register only changes when an operation completes.
module alu_shr_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] b,
    input  logic               arith,
    output logic [WIDTH-1:0]   r,
    output logic               busy,
    output logic               done
);

    // Counter must hold WIDTH itself, the saturated shift amount.
    localparam int CNT_W = $clog2(WIDTH + 1);

    shr_state_e       state_r;
    shr_state_e       state_nx_s;
    logic [WIDTH-1:0] work_r;
    logic [WIDTH-1:0] work_nx_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nx_s;
    logic             mode_r;
    logic             mode_nx_s;
    logic [WIDTH-1:0] r_nx_s;
    logic [WIDTH-1:0] shifted_s;
    logic [CNT_W-1:0] beff_s;

    alu_shr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .din  (work_r),
        .mode (mode_r),
        .dout (shifted_s)
    );

    // Saturate the requested amount at WIDTH; further shifts change nothing.
    always_comb begin
        beff_s = CNT_W'(0);
        if (32'(b) >= 32'(WIDTH)) begin
            beff_s = CNT_W'(WIDTH);
        end else begin
            beff_s = CNT_W'(b);
        end
    end

    // Next-state, datapath and result update for the shift sequencer.
    always_comb begin
        state_nx_s = state_r;
        work_nx_s  = work_r;
        count_nx_s = count_r;
        mode_nx_s  = mode_r;
        r_nx_s     = r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    work_nx_s  = a;
                    count_nx_s = beff_s;
                    mode_nx_s  = arith;
                    if (beff_s == CNT_W'(0)) begin
                        r_nx_s     = a;
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = SHIFT;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                // start is deliberately ignored here; the op in flight runs on.
                work_nx_s  = shifted_s;
                count_nx_s = count_r - CNT_W'(1);
                if (count_r == CNT_W'(1)) begin
                    r_nx_s     = shifted_s;
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            work_r  <= '0;
            count_r <= '0;
            mode_r  <= 1'b0;
            r       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            work_r  <= work_nx_s;
            count_r <= count_nx_s;
            mode_r  <= mode_nx_s;
            r       <= r_nx_s;
            busy    <= (state_nx_s == SHIFT);
            done    <= (state_nx_s == DONE);
        end
    end

endmodule : alu_shr_seq

// File: tb/tb_alu_shr_seq.sv
// Scoreboard bench for alu_shr_seq (WIDTH=8, SHAMT_W=4 to reach saturation):
// the driver queues expected results, a monitor checks each done pulse.
module tb_alu_shr_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [3:0] b = 4'h0;
    logic       arith = 1'b0;
    logic [7:0] r;
    logic       busy;
    logic       done;

    typedef struct {
        logic [7:0] res;
        int         cyc;
        int         blen;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         busy_cnt = 0;
    logic [7:0] last_r = 8'h00;

    alu_shr_seq #(
        .WIDTH   (8),
        .SHAMT_W (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .arith (arith),
        .r     (r),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    function automatic void flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event expected=none at cycle %0d", name, cyc);
    endfunction

    // Reference: plain shift operators on the full amount.
    function automatic logic [7:0] ref_shr(input logic [7:0] va, input logic [3:0] vb,
                                           input logic va_arith);
        logic signed [7:0] s;
        s = va;
        if (va_arith) return 8'(s >>> vb);
        else          return va >> vb;
    endfunction

    // Call at a negedge; waits for the unit to be free, then issues one op.
    task automatic issue(input logic [7:0] ia, input logic [3:0] ib, input logic iarith);
        int   guard;
        exp_t e;
        guard = 0;
        while (busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) flag("issue_timeout");
        start = 1'b1;
        a     = ia;
        b     = ib;
        arith = iarith;
        e.res  = ref_shr(ia, ib, iarith);
        e.blen = (ib > 4'd8) ? 8 : int'(ib);
        e.cyc  = cyc + 1 + e.blen;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 4'($urandom);
        arith = 1'($urandom);
    endtask

    // Pulse start with junk while shifting; must be ignored.
    task automatic poke(input logic [7:0] ia);
        if (busy) begin
            start = 1'b1;
            a     = ia;
            b     = 4'($urandom);
            arith = 1'($urandom);
            @(negedge clk);
            start = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    // Monitor: compare each done against the scoreboard and watch invariants.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            busy_cnt = 0;
            last_r   = 8'h00;
        end else begin
            if (busy && done) flag("busy_and_done");
            if (busy) begin
                busy_cnt++;
                if (q.size() == 0) flag("spurious_busy");
            end
            if (done) begin
                if (q.size() == 0) begin
                    flag("spurious_done");
                end else begin
                    e = q.pop_front();
                    chk("result", int'(r), int'(e.res));
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_len", busy_cnt, e.blen);
                    last_r = e.res;
                end
                busy_cnt = 0;
            end else begin
                chk("r_hold", int'(r), int'(last_r));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_r", int'(r), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue(8'hB4, 4'd3, 1'b0);
        issue(8'hB4, 4'd3, 1'b1);
        issue(8'h5A, 4'd0, 1'b0);
        issue(8'h5A, 4'd0, 1'b1);
        issue(8'h80, 4'd7, 1'b1);
        issue(8'h80, 4'd7, 1'b0);
        issue(8'h80, 4'd12, 1'b1);
        issue(8'h80, 4'd12, 1'b0);
        issue(8'hFF, 4'd8, 1'b0);
        repeat (12) @(negedge clk);

        issue(8'hF0, 4'd2, 1'b0);
        poke(8'h01);
        issue(8'h08, 4'd1, 1'b0);
        repeat (6) @(negedge clk);

        // Abort mid-shift: outputs clear at once and the op never completes.
        issue(8'hFF, 4'd5, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_r", int'(r), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(8'hC3, 4'd2, 1'b1);

        for (int i = 0; i < 150; i++) begin
            issue(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
            if ($urandom_range(0, 3) == 0) poke(8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        chk("drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_shr_seq

// File: doc/alu_shr_seq.md
Name: alu_shr_seq

Overview:
- Sequential right-shift unit, the counterpart of the ALU's combinational left shifter. It shifts one bit position per clock and supports logical and arithmetic modes.
- Sits in the ALU datapath as the multi-cycle SHR/SAR execution unit.
- Controlled by a start/busy/done handshake from the ALU sequencer.
- The result register holds its value until the next completed operation.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- SHAMT_W, 3, width of the shift-amount input.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled on rising edge when the unit is idle or in DONE.
- a  input  WIDTH  operand, captured with start.
- b  input  SHAMT_W  shift amount, captured with start.
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); captured with start.
- r  output  WIDTH  result; updated only on completion.
- busy  output  1  high while shifting.
- done  output  1  one-cycle completion pulse; r is valid from this cycle on.

Behaviour:
- Reset (async assert, sync-style deassert use): state=IDLE, r=0, busy=0, done=0, internal work/count/mode registers = 0. Reset mid-operation aborts it; no done is produced.
- States:
  - IDLE: start=1 captures a into work, b into count, arith into mode.
    - count==0 -> DONE (r<=a).
    - Otherwise -> SHIFT.
  - SHIFT: busy=1. Each edge: work <= work>>1, vacated MSB = mode ? work[WIDTH-1] : 0; count <= count-1.
    - The edge that shifts with count==1 also loads r with the shifted value and goes to DONE.
  - DONE: done=1 for exactly one cycle.
    - start=1 here is accepted exactly as in IDLE (back-to-back ops).
    - Otherwise -> IDLE.
- Latency: with E0 the capturing edge, done is high in the cycle after edge E(b_eff). For b=0, done is high in the cycle right after E0. busy is high for b_eff cycles.
- Saturation: b_eff = min(b, WIDTH). Amounts >= WIDTH give 0 (logical) or all copies of a[WIDTH-1] (arithmetic) after WIDTH shift cycles.
- start while in SHIFT is ignored: no capture, no error, and the current op is unaffected.
- a, b and arith may change freely after capture.
- r is stable during SHIFT and holds the previous result.
- busy and done are never high together.
- All outputs are registered.

Decomposition:
- Package alu_pkg: state encoding constants (IDLE, SHIFT, DONE) and the shift-mode constants (SHR_LOGICAL=0, SHR_ARITH=1), shared with the ALU sequencer and the left-shift unit.
- Optional sub-module alu_shr_step: combinational 1-bit right shift with fill-bit select, reused if a barrel version is built later.
- The FSM and counter stay in alu_shr_seq.

Test Plan:
- WIDTH=8. a=0xB4, b=3, arith=0, start 1 cycle -> busy high 3 cycles; done high in the cycle after the 3rd shift edge; r=0x16.
- a=0xB4, b=3, arith=1 -> r=0xF6, same timing.
- a=0x5A, b=0 (either mode) -> done in the cycle after the start edge, busy never high, r=0x5A.
- a=0x80, b=7, arith=1 -> r=0xFF. Repeat with arith=0 -> r=0x01. Also check SHAMT_W=4, b=12, a=0x80, arith=1 -> busy 8 cycles, r=0xFF.
- Sequencing: start a=0xF0, b=2, arith=0. Pulse start with a=0x01 mid-SHIFT -> ignored, r=0x3C. Assert start in the DONE cycle with a=0x08, b=1 -> accepted, next done gives r=0x04.
- Async reset: drop rst_n during SHIFT of a=0xFF, b=5 -> r=0, busy=0, done=0 immediately. After release, no done appears until a new start is issued.
